ym2610_pcm_mem_arbiter: RTL

Shares the single PCM memory read port between three requesters: the ADPCM-B reader, the ADPCM-A reader, and a CPU debug/readback port. It applies per-channel 24-bit base offsets so the ADPCM-A and ADPCM-B sample regions can be placed anywhere in memory. Offsets and a contention counter are exposed over Wishbone. The block sits between the A/B readers and the memory controller, and replaces ad-hoc "B active overrides A" muxing.

---
 rtl/ym2610_pcm_mem_arbiter_pkg.sv | 34 +++
 rtl/ym2610_pcm_mem_arbiter_if.sv | 42 ++++
 rtl/ym2610_pcm_mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ym2610_pcm_mem_arbiter_pkg.sv
// Shared types and constants for the YM2610 PCM memory arbiter.
// Arbitration order lives here so the top only sees a requester ID.
package ym2610_pcm_pkg;

    localparam int unsigned ADDR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_GNT_C = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_A    = 2'd1,
        REQ_B    = 2'd2,
        REQ_C    = 2'd3
    } req_t;

    localparam logic [1:0] REG_A_BASE     = 2'd0;
    localparam logic [1:0] REG_B_BASE     = 2'd1;
    localparam logic [1:0] REG_CTRL       = 2'd2;
    localparam logic [1:0] REG_CONTENTION = 2'd3;

    // B has the tightest real-time deadline, so it wins over A, then C.
    function automatic req_t pick_req(input logic a_v, input logic b_v, input logic c_v);
        if (b_v)      return REQ_B;
        else if (a_v) return REQ_A;
        else if (c_v) return REQ_C;
        else          return REQ_NONE;
    endfunction

endpackage

// File: rtl/ym2610_pcm_mem_arbiter_if.sv
// Wishbone, requester and memory-side signals of the PCM arbiter.
interface ym2610_pcm_mem_arbiter_if;
    import ym2610_pcm_pkg::*;

    logic [1:0]        wb_addr;
    logic [31:0]       wb_wdata;
    logic [31:0]       wb_rdata;
    logic              wb_cyc;
    logic              wb_we;
    logic              wb_ack;
    logic [ADDR_W-1:0] a_addr;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] b_addr;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] c_addr;
    logic              c_valid;
    logic              c_ready;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport slave (
        input  wb_addr, wb_wdata, wb_cyc, wb_we,
        input  a_addr, a_valid, b_addr, b_valid, c_addr, c_valid,
        input  mem_rdata, mem_ready,
        output wb_rdata, wb_ack, a_ready, b_ready, c_ready, rdata,
        output mem_addr, mem_valid
    );

    modport master (
        output wb_addr, wb_wdata, wb_cyc, wb_we,
        output a_addr, a_valid, b_addr, b_valid, c_addr, c_valid,
        output mem_rdata, mem_ready,
        input  wb_rdata, wb_ack, a_ready, b_ready, c_ready, rdata,
        input  mem_addr, mem_valid
    );

endinterface

// File: rtl/ym2610_pcm_mem_arbiter.sv
// Shares the PCM memory read port between ADPCM-B, ADPCM-A and a CPU port,
// applying per-channel base offsets; bases and contention count over Wishbone.
module ym2610_pcm_mem_arbiter
    import ym2610_pcm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] A_BASE_DEFAULT  = 24'h000000,
    parameter logic [ADDR_W-1:0] B_BASE_DEFAULT  = 24'h400000,
    parameter bit                ENABLE_CPU_PORT = 1'b1
) (
    input logic                      clk,
    input logic                      reset,
    ym2610_pcm_mem_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              r_mem_valid;
    logic              w_mem_valid_nxt;

    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic              r_cpu_en;
    logic [15:0]       r_contention;
    logic              r_wb_ack;
    logic [31:0]       r_wb_rdata;

    logic              w_a_v;
    logic              w_b_v;
    logic              w_c_v;
    req_t              w_pick;
    logic              w_contend;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_c_ready;
    logic              w_wb_wr;
    logic              w_wb_rd;
    logic [31:0]       w_reg_rd;
    logic              w_unused_wdata;

    assign w_a_v  = bus.a_valid;
    assign w_b_v  = bus.b_valid;
    assign w_c_v  = bus.c_valid && r_cpu_en && ENABLE_CPU_PORT;
    assign w_pick = pick_req(w_a_v, w_b_v, w_c_v);

    assign w_wb_wr = bus.wb_cyc && bus.wb_we && !r_wb_ack;
    assign w_wb_rd = bus.wb_cyc && !bus.wb_we && !r_wb_ack;
    assign w_unused_wdata = ^bus.wb_wdata[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_contend       = 1'b0;
        w_a_ready       = 1'b0;
        w_b_ready       = 1'b0;
        w_c_ready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Any two simultaneous valids means somebody loses arbitration.
                w_contend = (w_a_v && w_b_v) || (w_a_v && w_c_v) || (w_b_v && w_c_v);
                case (w_pick)
                    REQ_B: begin
                        w_state_nxt     = ST_GNT_B;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = bus.b_addr + r_b_base;
                    end
                    REQ_A: begin
                        w_state_nxt     = ST_GNT_A;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = bus.a_addr + r_a_base;
                    end
                    REQ_C: begin
                        w_state_nxt     = ST_GNT_C;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = bus.c_addr;
                    end
                    default: ;
                endcase
            end
            ST_GNT_A: begin
                w_a_ready = bus.mem_ready;
                w_contend = w_b_v || w_c_v;
            end
            ST_GNT_B: begin
                w_b_ready = bus.mem_ready;
                w_contend = w_a_v || w_c_v;
            end
            ST_GNT_C: begin
                w_c_ready = bus.mem_ready;
                w_contend = w_a_v || w_b_v;
            end
            default: ;
        endcase
        if (r_state != ST_IDLE && bus.mem_ready) begin
            w_state_nxt     = ST_IDLE;
            w_mem_valid_nxt = 1'b0;
        end
    end

    always_comb begin
        w_reg_rd = '0;
        case (bus.wb_addr)
            REG_A_BASE:     w_reg_rd = {8'b0, r_a_base};
            REG_B_BASE:     w_reg_rd = {8'b0, r_b_base};
            REG_CTRL:       w_reg_rd = {31'b0, r_cpu_en};
            REG_CONTENTION: w_reg_rd = {16'b0, r_contention};
            default:        w_reg_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_ack     <= 1'b0;
            r_wb_rdata   <= '0;
            r_a_base     <= A_BASE_DEFAULT;
            r_b_base     <= B_BASE_DEFAULT;
            r_cpu_en     <= 1'b1;
            r_contention <= '0;
        end else begin
            r_wb_ack   <= bus.wb_cyc && !r_wb_ack;
            r_wb_rdata <= w_wb_rd ? w_reg_rd : '0;
            if (w_wb_wr && bus.wb_addr == REG_A_BASE) r_a_base <= bus.wb_wdata[ADDR_W-1:0];
            if (w_wb_wr && bus.wb_addr == REG_B_BASE) r_b_base <= bus.wb_wdata[ADDR_W-1:0];
            if (w_wb_wr && bus.wb_addr == REG_CTRL)   r_cpu_en <= bus.wb_wdata[0];
            if (w_wb_wr && bus.wb_addr == REG_CONTENTION) begin
                r_contention <= '0;
            end else if (w_contend && r_contention != '1) begin
                r_contention <= r_contention + 16'd1;
            end
        end
    end

    assign bus.a_ready   = w_a_ready;
    assign bus.b_ready   = w_b_ready;
    assign bus.c_ready   = w_c_ready;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_valid = r_mem_valid;
    assign bus.wb_ack    = r_wb_ack;
    assign bus.wb_rdata  = r_wb_rdata;

endmodule
